// File: rtl/bus_loader_if.sv
// Handshake and shared-bus signal bundle for bus_loader.
// The master side drives the requests; the slave side is the loader itself.
interface bus_loader_if;
  logic       start;
  logic [7:0] load_val;
  logic       mon_en;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic       load_o;
  logic       busy;
  logic       done;
  logic       pass;
  logic       seq_err;
  logic [7:0] err_cnt;

  modport master (
    output start, load_val, mon_en, bus_in,
    input  bus_out, bus_oe, load_o, busy, done, pass, seq_err, err_cnt
  );

  modport slave (
    input  start, load_val, mon_en, bus_in,
    output bus_out, bus_oe, load_o, busy, done, pass, seq_err, err_cnt
  );
endinterface

// File: rtl/bus_loader.sv
// Preloads a counter peer over a shared bus (assert, drive, release, verify)
// and monitors the peer's count stream for increment errors while idle.
module bus_loader #(
  parameter int TURN_CYC   = 3,
  parameter int DRIVE_CYC  = 4,
  parameter int SETTLE_CYC = 2
) (
  input logic         clk,
  input logic         rst,
  bus_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ASSERT, DRIVE, RELEASE, VERIFY} state_t;

  localparam logic [3:0] TURN_T   = 4'(TURN_CYC - 1);
  localparam logic [3:0] DRIVE_T  = 4'(DRIVE_CYC - 1);
  localparam logic [3:0] SETTLE_T = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] PASS_LIM = 8'(SETTLE_CYC + 2);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] prev_q, prev_d;
  logic       prev_vld_q, prev_vld_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       seq_err_q;
  logic       load_q, busy_q, done_q;
  logic [7:0] oe_q, out_q;
  logic       mon_sample, mon_err;
  logic [7:0] diff;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hold_d  = bus.load_val;
          state_d = ASSERT;
          timer_d = TURN_T;
        end
      end
      ASSERT: begin
        if (timer_q == 4'd0) begin
          state_d = DRIVE;
          timer_d = DRIVE_T;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      DRIVE: begin
        if (timer_q == 4'd0) begin
          state_d = RELEASE;
          timer_d = SETTLE_T;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      RELEASE: begin
        if (timer_q == 4'd0) begin
          state_d = VERIFY;
          timer_d = 4'd0;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      VERIFY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = 4'd0;
      end
    endcase
  end

  // 8-bit wrap makes FF->00 a legal increment with no special case.
  always_comb begin
    mon_sample = (state_q == IDLE) && bus.mon_en;
    mon_err    = mon_sample && prev_vld_q && (bus.bus_in != (prev_q + 8'd1));
    prev_d     = mon_sample ? bus.bus_in : prev_q;
    prev_vld_d = mon_sample;
    err_cnt_d  = err_cnt_q;
    if (mon_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Bus-facing outputs are decoded from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= 4'd0;
      hold_q     <= 8'h00;
      prev_q     <= 8'h00;
      prev_vld_q <= 1'b0;
      err_cnt_q  <= 8'h00;
      seq_err_q  <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      oe_q       <= 8'h00;
      out_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      err_cnt_q  <= err_cnt_d;
      seq_err_q  <= mon_err;
      load_q     <= (state_d == ASSERT) || (state_d == DRIVE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == VERIFY);
      oe_q       <= (state_d == DRIVE) ? 8'hFF : 8'h00;
      out_q      <= (state_d == DRIVE) ? hold_d : 8'h00;
    end
  end

  assign diff        = bus.bus_in - hold_q;
  assign bus.pass    = done_q && (diff <= PASS_LIM);
  assign bus.bus_out = out_q;
  assign bus.bus_oe  = oe_q;
  assign bus.load_o  = load_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.seq_err = seq_err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bus_loader.sv
// Directed and randomized checks of bus_loader against a cycle-index reference
// of the transaction timeline and a rule-based model of the count monitor.
module tb_bus_loader;
  localparam int T   = 3;
  localparam int D   = 4;
  localparam int S   = 2;
  localparam int TOT = T + D + S + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] m_prev = 8'h00;
  bit         m_vld  = 1'b0;
  int         exp_cnt = 0;

  bus_loader_if b ();

  bus_loader #(.TURN_CYC(T), .DRIVE_CYC(D), .SETTLE_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; peer either counts up from v after release or returns const_val.
  task automatic run_txn(input logic [7:0] v, input bit counter_peer, input logic [7:0] const_val);
    logic [7:0] bin;
    logic       exp_pass;
    logic       got_pass;
    got_pass   = 1'b0;
    exp_pass   = 1'b0;
    b.mon_en   = 1'b0;
    b.start    = 1'b1;
    b.load_val = v;
    b.bus_in   = 8'h00;
    @(posedge clk);
    #2;
    b.start    = 1'b0;
    b.load_val = 8'($urandom);
    for (int k = 1; k <= TOT + 2; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #2;
      end
      if (k > T + D) bin = counter_peer ? (v + 8'(k - (T + D + 1))) : const_val;
      else bin = 8'h00;
      b.bus_in = bin;
      @(negedge clk);
      chk($sformatf("load_o k=%0d", k), b.load_o, (k <= T + D));
      chk($sformatf("bus_oe k=%0d", k), b.bus_oe, (k > T && k <= T + D) ? 8'hFF : 8'h00);
      chk($sformatf("bus_out k=%0d", k), b.bus_out, (k > T && k <= T + D) ? v : 8'h00);
      chk($sformatf("busy k=%0d", k), b.busy, (k <= TOT));
      chk($sformatf("done k=%0d", k), b.done, (k == TOT));
      if (k == TOT) begin
        exp_pass = (8'(bin - v) <= 8'(S + 2));
        got_pass = b.pass;
        chk($sformatf("pass k=%0d", k), b.pass, exp_pass);
      end else begin
        chk($sformatf("pass k=%0d", k), b.pass, 1'b0);
      end
    end
    $display("txn load_val=%02h peer=%s verify_pass=%0d expected_pass=%0d",
             v, counter_peer ? "count" : "const", got_pass, exp_pass);
  endtask

  // One monitored sample; expected flag comes from the increment rule on the bench's own history.
  task automatic mon_step(input logic [7:0] val);
    logic exp_err;
    logic [7:0] nxt;
    nxt      = m_prev + 8'd1;
    exp_err  = m_vld && (val != nxt);
    if (exp_err && exp_cnt < 255) exp_cnt++;
    m_prev   = val;
    m_vld    = 1'b1;
    b.mon_en = 1'b1;
    b.bus_in = val;
    @(posedge clk);
    #5;
    chk($sformatf("seq_err val=%02h", val), b.seq_err, exp_err);
    chk($sformatf("err_cnt val=%02h", val), b.err_cnt, exp_cnt);
  endtask

  initial begin
    logic [7:0] seq [7];
    logic [7:0] v, val;
    int seq_pulses;
    int dcount;

    b.start = 1'b0; b.load_val = 8'h00; b.mon_en = 1'b0; b.bus_in = 8'h00;
    #3;
    chk("rst bus_oe", b.bus_oe, 8'h00);
    chk("rst bus_out", b.bus_out, 8'h00);
    chk("rst load_o", b.load_o, 1'b0);
    chk("rst busy", b.busy, 1'b0);
    chk("rst done", b.done, 1'b0);
    chk("rst pass", b.pass, 1'b0);
    chk("rst seq_err", b.seq_err, 1'b0);
    chk("rst err_cnt", b.err_cnt, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    run_txn(8'hA5, 1'b1, 8'h00);
    run_txn(8'hA5, 1'b0, 8'h10);
    run_txn(8'hFE, 1'b0, 8'h01);
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      run_txn(v, 1'b0, v + 8'($urandom_range(0, 8)));
    end

    seq[0] = 8'hFD; seq[1] = 8'hFE; seq[2] = 8'hFF; seq[3] = 8'h00;
    seq[4] = 8'h01; seq[5] = 8'h05; seq[6] = 8'h06;
    seq_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      mon_step(seq[i]);
      if (b.seq_err) seq_pulses++;
    end
    chk("seq_err pulse total", seq_pulses, 1);
    b.mon_en = 1'b0;
    m_vld = 1'b0;

    // Reset in the second DRIVE cycle must release the bus without waiting for a clock.
    b.start = 1'b1; b.load_val = 8'h3C;
    @(posedge clk);
    #2;
    b.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre-rst bus_oe", b.bus_oe, 8'hFF);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    chk("async bus_oe", b.bus_oe, 8'h00);
    chk("async bus_out", b.bus_out, 8'h00);
    chk("async load_o", b.load_o, 1'b0);
    chk("async busy", b.busy, 1'b0);
    chk("async done", b.done, 1'b0);
    chk("async err_cnt", b.err_cnt, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_txn(8'h5A, 1'b1, 8'h00);

    for (int i = 0; i < 301; i++) begin
      val = m_vld ? (m_prev + 8'd2 + 8'($urandom_range(0, 200))) : 8'($urandom);
      mon_step(val);
    end
    chk("err_cnt saturated", b.err_cnt, 8'hFF);

    // Monitor sample and start in the same idle cycle; then a start while busy is dropped.
    b.mon_en = 1'b1; b.bus_in = 8'h10;
    @(posedge clk);
    #2;
    b.bus_in = 8'h20; b.start = 1'b1; b.load_val = 8'h77;
    @(posedge clk);
    #2;
    b.start = 1'b0; b.mon_en = 1'b0;
    m_vld = 1'b0;
    @(negedge clk);
    chk("same-cycle seq_err", b.seq_err, 1'b1);
    chk("same-cycle busy", b.busy, 1'b1);
    chk("same-cycle err_cnt", b.err_cnt, 8'hFF);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (b.done) dcount++;
      b.start = (c == 1);
    end
    chk("done pulses with start while busy", dcount, 1);
    chk("idle after ignored start", b.busy, 1'b0);
    $display("txn load_val=77 start-while-busy done_pulses=%0d", dcount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
